// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared widths, register constants and FSM encodings for the
//               pipeline control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int REG_ADDR   = 5;
    localparam int INST_ADDR  = 32;
    localparam int PIPE_CNT_W = 4;

    localparam logic [REG_ADDR-1:0] ZERO_REG = '0;

    localparam logic [0:0] PIPE_ST_IDLE = 1'b0;
    localparam logic [0:0] PIPE_ST_MUL  = 1'b1;

    typedef logic [REG_ADDR-1:0]  reg_addr_t;
    typedef logic [INST_ADDR-1:0] inst_addr_t;

    // x0 is hard-wired, so a write to it can never feed a later read.
    function automatic logic reg_match(input reg_addr_t wr_addr, input reg_addr_t rd_addr);
        return (wr_addr != ZERO_REG) && (wr_addr == rd_addr);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Hazard inputs and stall/flush/redirect outputs between the
//               pipeline datapath (master) and the control unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    reg_addr_t  id_reg1_r_addr_i;
    reg_addr_t  id_reg2_r_addr_i;
    logic       ex_mem_r_ena_i;
    reg_addr_t  ex_reg_w_addr_i;
    logic       ex_jump_ena_i;
    inst_addr_t ex_jump_addr_i;
    logic       ex_mul_req_i;

    logic       hold_pc_o;
    logic       hold_if_id_o;
    logic       hold_id_ex_o;
    logic       flush_if_id_o;
    logic       flush_id_ex_o;
    logic       flush_ex_mem_o;
    logic       jump_ena_o;
    inst_addr_t jump_addr_o;
    logic       mul_busy_o;
    logic       mul_done_o;

    modport master (
        output id_reg1_r_addr_i, id_reg2_r_addr_i, ex_mem_r_ena_i, ex_reg_w_addr_i,
               ex_jump_ena_i, ex_jump_addr_i, ex_mul_req_i,
        input  hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
               flush_ex_mem_o, jump_ena_o, jump_addr_o, mul_busy_o, mul_done_o
    );

    modport slave (
        input  id_reg1_r_addr_i, id_reg2_r_addr_i, ex_mem_r_ena_i, ex_reg_w_addr_i,
               ex_jump_ena_i, ex_jump_addr_i, ex_mul_req_i,
        output hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
               flush_ex_mem_o, jump_ena_o, jump_addr_o, mul_busy_o, mul_done_o
    );

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_load_use_det.sv
// ============================================================================
// Module      : load_use_det
// Description : Flags a load in EX whose destination is read by the
//               instruction currently in decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_det
    import pipe_ctrl_pkg::*;
(
    input  wire reg_addr_t i_reg1_r_addr,
    input  wire reg_addr_t i_reg2_r_addr,
    input  wire logic      i_ex_mem_r_ena,
    input  wire reg_addr_t i_ex_reg_w_addr,
    output logic           o_hazard
);

    assign o_hazard = i_ex_mem_r_ena &&
                      (reg_match(i_ex_reg_w_addr, i_reg1_r_addr) ||
                       reg_match(i_ex_reg_w_addr, i_reg2_r_addr));

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Stall/bubble/flush sequencing for the 5-stage RV32IM pipe.
//               PIPE_CTRL_MUL_MULTICYCLE_EN enables the multi-cycle MUL FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4
)(
    input  wire logic   clk,
    input  wire logic   rst_n,
    pipe_ctrl_if.slave  bus
);

    logic       w_load_use;
    logic       w_hold_pc;
    logic       w_hold_if_id;
    logic       w_hold_id_ex;
    logic       w_flush_if_id;
    logic       w_flush_id_ex;
    logic       w_flush_ex_mem;
    logic       w_jump_ena;
    inst_addr_t w_jump_addr;
    logic       w_mul_busy;
    logic       w_mul_done;

    load_use_det u_load_use_det (
        .i_reg1_r_addr   (bus.id_reg1_r_addr_i),
        .i_reg2_r_addr   (bus.id_reg2_r_addr_i),
        .i_ex_mem_r_ena  (bus.ex_mem_r_ena_i),
        .i_ex_reg_w_addr (bus.ex_reg_w_addr_i),
        .o_hazard        (w_load_use)
    );

`ifdef PIPE_CTRL_MUL_MULTICYCLE_EN
    // First cycle of the multiply is spent in IDLE, so the counter covers the rest minus the result cycle.
    localparam logic [PIPE_CNT_W-1:0] C_CNT_INIT =
        (MUL_LAT >= 2) ? PIPE_CNT_W'(MUL_LAT - 2) : '0;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [PIPE_CNT_W-1:0] r_cnt;
    logic [PIPE_CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PIPE_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = clk ^ (MUL_LAT == 0);
`endif

    always_comb begin
        w_hold_pc      = 1'b0;
        w_hold_if_id   = 1'b0;
        w_hold_id_ex   = 1'b0;
        w_flush_if_id  = 1'b0;
        w_flush_id_ex  = 1'b0;
        w_flush_ex_mem = 1'b0;
        w_jump_ena     = 1'b0;
        w_jump_addr    = '0;
        w_mul_busy     = 1'b0;
        w_mul_done     = 1'b0;
`ifdef PIPE_CTRL_MUL_MULTICYCLE_EN
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
`endif
        // Outputs are gated by rst_n so the pipe sees no control while in reset.
        if (rst_n) begin
`ifdef PIPE_CTRL_MUL_MULTICYCLE_EN
            if (r_state == PIPE_ST_MUL) begin
                // EX is frozen on the multiply, so a jump seen now is stale and ignored.
                w_mul_busy = 1'b1;
                if (r_cnt != '0) begin
                    w_hold_pc      = 1'b1;
                    w_hold_if_id   = 1'b1;
                    w_hold_id_ex   = 1'b1;
                    w_flush_ex_mem = 1'b1;
                    w_cnt_nxt      = r_cnt - 1'b1;
                end else begin
                    w_mul_done  = 1'b1;
                    w_state_nxt = PIPE_ST_IDLE;
                end
            end else
`endif
            if (bus.ex_jump_ena_i) begin
                w_jump_ena    = 1'b1;
                w_jump_addr   = bus.ex_jump_addr_i;
                w_flush_if_id = 1'b1;
                w_flush_id_ex = 1'b1;
            end
`ifdef PIPE_CTRL_MUL_MULTICYCLE_EN
            else if (bus.ex_mul_req_i) begin
                if (MUL_LAT == 1) begin
                    w_mul_done = 1'b1;
                end else begin
                    w_hold_pc      = 1'b1;
                    w_hold_if_id   = 1'b1;
                    w_hold_id_ex   = 1'b1;
                    w_flush_ex_mem = 1'b1;
                    w_state_nxt    = PIPE_ST_MUL;
                    w_cnt_nxt      = C_CNT_INIT;
                end
            end
`endif
            else if (w_load_use) begin
                w_hold_pc     = 1'b1;
                w_hold_if_id  = 1'b1;
                w_flush_id_ex = 1'b1;
            end
`ifndef PIPE_CTRL_MUL_MULTICYCLE_EN
            w_mul_done = bus.ex_mul_req_i;
`endif
        end
    end

    assign bus.hold_pc_o      = w_hold_pc;
    assign bus.hold_if_id_o   = w_hold_if_id;
    assign bus.hold_id_ex_o   = w_hold_id_ex;
    assign bus.flush_if_id_o  = w_flush_if_id;
    assign bus.flush_id_ex_o  = w_flush_id_ex;
    assign bus.flush_ex_mem_o = w_flush_ex_mem;
    assign bus.jump_ena_o     = w_jump_ena;
    assign bus.jump_addr_o    = w_jump_addr;
    assign bus.mul_busy_o     = w_mul_busy;
    assign bus.mul_done_o     = w_mul_done;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Scoreboard bench for pipe_ctrl; expectations follow
//               PIPE_CTRL_MUL_MULTICYCLE_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int MUL_LAT = 4;

    // Flag vector bit positions
    localparam int F_HPC = 8, F_HIF = 7, F_HEX = 6, F_FIF = 5, F_FEX = 4;
    localparam int F_FEM = 3, F_JMP = 2, F_BSY = 1, F_DN  = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if u_if ();

    pipe_ctrl #(.MUL_LAT(MUL_LAT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    typedef struct {
        string       tag;
        logic [8:0]  flags;
        logic [31:0] addr;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   m_busy   = 1'b0;
    int   m_left   = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    function automatic logic [8:0] obs_flags();
        return {u_if.hold_pc_o, u_if.hold_if_id_o, u_if.hold_id_ex_o,
                u_if.flush_if_id_o, u_if.flush_id_ex_o, u_if.flush_ex_mem_o,
                u_if.jump_ena_o, u_if.mul_busy_o, u_if.mul_done_o};
    endfunction

    // One cycle: drive inputs after the edge, predict, then compare mid-cycle.
    task automatic step(input string tag, input logic rst_v,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic ld, input logic [4:0] rd,
                        input logic jmp, input logic [31:0] ja, input logic mul);
        exp_t e;
        exp_t got;
        logic hz;
        @(posedge clk);
        #1;
        rst_n                 = rst_v;
        u_if.id_reg1_r_addr_i = rs1;
        u_if.id_reg2_r_addr_i = rs2;
        u_if.ex_mem_r_ena_i   = ld;
        u_if.ex_reg_w_addr_i  = rd;
        u_if.ex_jump_ena_i    = jmp;
        u_if.ex_jump_addr_i   = ja;
        u_if.ex_mul_req_i     = mul;

        e.tag   = tag;
        e.flags = '0;
        e.addr  = '0;
        hz = ld && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        if (!rst_v) begin
            m_busy = 1'b0;
            m_left = 0;
        end else begin
`ifdef PIPE_CTRL_MUL_MULTICYCLE_EN
            if (m_busy) begin
                e.flags[F_BSY] = 1'b1;
                if (m_left > 1) begin
                    e.flags[F_HPC] = 1'b1; e.flags[F_HIF] = 1'b1;
                    e.flags[F_HEX] = 1'b1; e.flags[F_FEM] = 1'b1;
                end else begin
                    e.flags[F_DN] = 1'b1;
                end
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end else if (jmp) begin
                e.flags[F_JMP] = 1'b1; e.flags[F_FIF] = 1'b1; e.flags[F_FEX] = 1'b1;
                e.addr = ja;
            end else if (mul) begin
                if (MUL_LAT == 1) begin
                    e.flags[F_DN] = 1'b1;
                end else begin
                    e.flags[F_HPC] = 1'b1; e.flags[F_HIF] = 1'b1;
                    e.flags[F_HEX] = 1'b1; e.flags[F_FEM] = 1'b1;
                    m_busy = 1'b1;
                    m_left = MUL_LAT - 1;
                end
            end else if (hz) begin
                e.flags[F_HPC] = 1'b1; e.flags[F_HIF] = 1'b1; e.flags[F_FEX] = 1'b1;
            end
`else
            if (jmp) begin
                e.flags[F_JMP] = 1'b1; e.flags[F_FIF] = 1'b1; e.flags[F_FEX] = 1'b1;
                e.addr = ja;
            end else if (hz) begin
                e.flags[F_HPC] = 1'b1; e.flags[F_HIF] = 1'b1; e.flags[F_FEX] = 1'b1;
            end
            e.flags[F_DN] = mul;
`endif
        end
        q_exp.push_back(e);

        @(negedge clk);
        got = q_exp.pop_front();
        check_value({got.tag, ".flags"}, 32'(obs_flags()), 32'(got.flags));
        check_value({got.tag, ".addr"}, u_if.jump_addr_o, got.addr);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic mul_cycle(input string tag);
        step(tag, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            step("reset", 1'b0, 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                 1'($urandom), $urandom, 1'($urandom));
        idle("post_reset");
        for (int i = 0; i < MUL_LAT; i++) mul_cycle("mul_after_reset");
        idle("mul_after_reset_tail");

        step("load_use", 1'b1, 5'd7, 5'd5, 1'b1, 5'd5, 1'b0, 32'd0, 1'b0);
        step("load_use_bubble", 1'b1, 5'd7, 5'd5, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
        step("load_use_rs1", 1'b1, 5'd9, 5'd4, 1'b1, 5'd9, 1'b0, 32'd0, 1'b0);
        step("load_x0", 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 32'd0, 1'b0);
        step("load_no_match", 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 32'd0, 1'b0);

        step("jump_vs_load_use", 1'b1, 5'd7, 5'd5, 1'b1, 5'd5, 1'b1, 32'h0000_0100, 1'b0);
        step("jump_alone", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 32'hDEAD_BEE0, 1'b0);
        idle("jump_tail");

        for (int i = 0; i < 2 * MUL_LAT; i++) mul_cycle("mul_b2b");
        idle("mul_b2b_tail");

        mul_cycle("mul_jump_start");
        step("mul_jump_ignored", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h0000_0200, 1'b1);
        for (int i = 2; i < MUL_LAT; i++) mul_cycle("mul_jump_rest");
        idle("mul_jump_tail");

        mul_cycle("mul_rst_start");
        step("mul_rst_mid", 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < MUL_LAT + 1; i++) idle("mul_rst_after");

        for (int i = 0; i < 60; i++)
            step("random", 1'b1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), $urandom,
                 m_busy ? 1'b1 : ($urandom_range(0, 4) == 0));
        for (int i = 0; i < MUL_LAT; i++) idle("drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
